// File: rtl/mult_req_scheduler.sv
// mult_req_scheduler: shares one 8x8 multiplier between the UART and SPI byte
// streams. Each source collects two operand bytes (A then B). A pending source
// is granted, the multiplier is run through its start/done handshake, and the
// 16-bit product goes back high byte first on the source's own interface.
// Optional build macro MULT_SCHED_FIXED_PRIO_EN: UART always wins a tie and the
// round-robin pointer is removed. Default build uses round robin.
module mult_req_scheduler #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_data,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_product,
  input  logic        uart_tx_ready,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  output logic        spi_tx_load,
  output logic [7:0]  spi_tx_data,
  input  logic        spi_tx_done,
  output logic        busy,
  output logic        owner,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam logic [9:0] TO_CNT = 10'(TIMEOUT);

  typedef enum logic [1:0] {COL_EMPTY, COL_HAVE_A, COL_PENDING} col_state_t;
  typedef enum logic [2:0] {IDLE, START, WAIT_MUL, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT} state_t;

  // Source index 0 is UART, 1 is SPI throughout.
  state_t     state, state_next;
  col_state_t col     [2];
  logic [7:0] col_a   [2];
  logic [7:0] col_b   [2];
  logic [9:0] col_cnt [2];
  logic [7:0] rx_data [2];
  logic [1:0] rx_valid, pend, rel, expire, drop;
  logic       grant_spi, guard;
  logic [7:0] prod_lo;

  assign rx_valid   = {spi_rx_valid, uart_rx_valid};
  assign rx_data[0] = uart_rx_data;
  assign rx_data[1] = spi_rx_data;
  assign busy       = (state != IDLE);

  // Per-source status: pending, release on product return, timeout expiry, dropped byte.
  always_comb begin
    pend   = '0;
    rel    = '0;
    expire = '0;
    drop   = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i]   = (col[i] == COL_PENDING);
      rel[i]    = (state == WAIT_MUL) && mul_done && (owner == 1'(i));
      // A byte arriving on the expiry cycle wins, so expiry requires silence.
      expire[i] = (col[i] == COL_HAVE_A) && !rx_valid[i] && (col_cnt[i] == TO_CNT);
      drop[i]   = pend[i] && rx_valid[i];
    end
  end

  // Collector state, timeout counters and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        col[i]     <= COL_EMPTY;
        col_cnt[i] <= '0;
      end
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (col[i])
          COL_EMPTY: begin
            if (rx_valid[i]) begin
              col[i]     <= COL_HAVE_A;
              col_cnt[i] <= '0;
            end
          end
          COL_HAVE_A: begin
            if (rx_valid[i])    col[i]     <= COL_PENDING;
            else if (expire[i]) col[i]     <= COL_EMPTY;
            else                col_cnt[i] <= col_cnt[i] + 10'd1;
          end
          COL_PENDING: begin
            // A byte landing on the release cycle is still dropped (flagged by drop).
            if (rel[i]) col[i] <= COL_EMPTY;
          end
          default: col[i] <= COL_EMPTY;
        endcase
      end
      err_timeout <= |expire;
      err_overrun <= |drop;
    end
  end

  // Operand capture; contents only matter once the collector state says so.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid[i] && col[i] == COL_EMPTY)  col_a[i] <= rx_data[i];
      if (rx_valid[i] && col[i] == COL_HAVE_A) col_b[i] <= rx_data[i];
    end
  end

`ifdef MULT_SCHED_FIXED_PRIO_EN
  // Fixed priority: SPI only wins when UART is not pending.
  always_comb begin
    grant_spi = pend[1] && !pend[0];
  end
`else
  logic prio;  // 0: UART preferred on a tie, 1: SPI preferred

  // Round robin: on a tie the pointer decides, otherwise the lone requester wins.
  always_comb begin
    grant_spi = pend[1] && (!pend[0] || prio);
  end

  // Pointer moves away from whichever source was just granted.
  always_ff @(posedge clk) begin
    if (reset)                   prio <= 1'b0;
    else if (state == IDLE && |pend) prio <= !grant_spi;
  end
`endif

  // Next-state and strobe decode for the transaction sequencer.
  always_comb begin
    state_next    = state;
    mul_start     = 1'b0;
    uart_tx_start = 1'b0;
    spi_tx_load   = 1'b0;
    case (state)
      IDLE:     if (|pend) state_next = START;
      START: begin
        mul_start  = 1'b1;
        state_next = WAIT_MUL;
      end
      WAIT_MUL: if (mul_done) state_next = TX_HI;
      TX_HI, TX_LO: begin
        if (owner) begin
          spi_tx_load = 1'b1;
          state_next  = (state == TX_HI) ? TX_HI_WAIT : TX_LO_WAIT;
        end else if (uart_tx_ready) begin
          uart_tx_start = 1'b1;
          state_next    = (state == TX_HI) ? TX_HI_WAIT : TX_LO_WAIT;
        end
      end
      TX_HI_WAIT, TX_LO_WAIT: begin
        // UART ready may still show the pre-start value during the guard cycle.
        if ((owner && spi_tx_done) || (!owner && !guard && uart_tx_ready))
          state_next = (state == TX_HI_WAIT) ? TX_LO : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, grant, operand and transmit-byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      guard        <= 1'b0;
      owner        <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      uart_tx_data <= '0;
      spi_tx_data  <= '0;
    end else begin
      state <= state_next;
      guard <= (state == TX_HI) || (state == TX_LO);
      if (state == IDLE && |pend) begin
        owner <= grant_spi;
        mul_a <= col_a[grant_spi];
        mul_b <= col_b[grant_spi];
      end
      if (state == WAIT_MUL && mul_done) begin
        if (owner) spi_tx_data  <= mul_product[15:8];
        else       uart_tx_data <= mul_product[15:8];
      end
      if (state == TX_HI_WAIT && state_next == TX_LO) begin
        if (owner) spi_tx_data  <= prod_lo;
        else       uart_tx_data <= prod_lo;
      end
    end
  end

  // Low product byte held until the high byte has gone out.
  always_ff @(posedge clk) begin
    if (state == WAIT_MUL && mul_done) prod_lo <= mul_product[7:0];
  end

endmodule

// File: doc/mult_req_scheduler.md
Name: mult_req_scheduler

Overview:
Sequencer and arbiter that shares one 8x8 multiplier between the UART and SPI byte streams in the multiplier/UART/SPI top. Each interface delivers two operand bytes (A then B). The scheduler grants one requester, runs the multiplier through its start/done handshake, and returns the 16-bit product high byte first on the same interface that sent the operands.

Parameters:
TIMEOUT, 1023, cycles allowed between operand A and operand B before A is discarded (10-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uart_rx_valid  in  1  one-cycle strobe, uart_rx_data valid
uart_rx_data  in  8  received UART byte
spi_rx_valid  in  1  one-cycle strobe, spi_rx_data valid
spi_rx_data  in  8  received SPI byte
mul_start  out  1  one-cycle pulse, launches multiplier
mul_a  out  8  operand A, held stable from mul_start until mul_done
mul_b  out  8  operand B, held stable from mul_start until mul_done
mul_done  in  1  one-cycle strobe, mul_product valid
mul_product  in  16  product
uart_tx_ready  in  1  UART transmitter idle
uart_tx_start  out  1  one-cycle pulse, send uart_tx_data
uart_tx_data  out  8  byte to transmit
spi_tx_load  out  1  one-cycle pulse, load spi_tx_data into SPI shifter
spi_tx_data  out  8  byte for MISO
spi_tx_done  in  1  one-cycle strobe, SPI byte shifted out
busy  out  1  high whenever FSM is not IDLE
owner  out  1  current or last grant: 0 = UART, 1 = SPI
err_timeout  out  1  one-cycle pulse, a partial operand was discarded
err_overrun  out  1  one-cycle pulse, a byte was dropped because its source was already pending

Behaviour:
- Reset: every output 0. Both collectors empty, FSM in IDLE, round-robin pointer set to UART.
- Collectors: one per source. States are EMPTY, HAVE_A and PENDING. A valid byte in EMPTY is stored as A and moves to HAVE_A. A valid byte in HAVE_A is stored as B and moves to PENDING. A valid byte in PENDING is dropped and pulses err_overrun the next cycle.
- Timeout: the per-source counter runs only in HAVE_A and resets on every valid byte. When it reaches TIMEOUT, the collector returns to EMPTY and err_timeout pulses. A valid byte arriving in the same cycle as the timeout wins: it is stored as B and no error is raised.
- FSM states: IDLE, START, WAIT_MUL, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT.
- IDLE: if any collector is PENDING, grant it, latch owner, drive mul_a/mul_b, go to START.
- Arbitration: with both pending, the grant goes to the source not granted last (round robin). The pointer updates on every grant.
- START: assert mul_start for exactly one cycle, go to WAIT_MUL.
- WAIT_MUL: on mul_done, latch mul_product, release the granted collector to EMPTY, go to TX_HI. The collector may accept new bytes from the next cycle.
- TX_HI and TX_LO send product[15:8], then product[7:0].
  - UART owner: wait for uart_tx_ready=1, then pulse uart_tx_start with the byte. In the *_WAIT state, ignore uart_tx_ready for one guard cycle, then advance when uart_tx_ready=1.
  - SPI owner: pulse spi_tx_load with the byte immediately. In the *_WAIT state, advance on spi_tx_done.
  - TX_LO_WAIT returns to IDLE.
- Latency, UART path with all ready: second byte strobe at cycle N; collector PENDING at N+1; grant at N+1; mul_start high at N+2.
- Data outputs hold their last value between transactions. Strobe outputs are never asserted for more than one cycle.
- The non-granted source keeps collecting while a transaction is in progress.
- Reset mid-operation: the FSM returns to IDLE and the collectors empty on the next edge. Any pending mul_done is ignored in IDLE.
- A mul_done or spi_tx_done arriving outside its wait state is ignored.

Optional Feature:
- Macro: MULT_SCHED_FIXED_PRIO_EN.
- Defined: UART always wins when both sources are pending, and the round-robin pointer is removed.
- Undefined: round robin as described in Behaviour.

Test Plan:
- UART bytes 0x0C, 0x0D with a multiplier model of 4-cycle latency -> mul_a=0x0C, mul_b=0x0D, mul_start at N+2; uart_tx_start pulses carry 0x00, then 0x9C; busy returns to 0.
- SPI bytes 0xFF, 0xFF -> product 0xFE01; spi_tx_load pulses carry 0xFE, then 0x01; no UART strobes; owner=1.
- Both sources become PENDING in the same cycle, from reset -> UART is served first, SPI second.
  - With MULT_SCHED_FIXED_PRIO_EN, a repeated race always serves UART.
  - Without it, a repeated race alternates between UART and SPI.
- UART byte 0x05, then silence for TIMEOUT cycles -> err_timeout pulses once; the next two bytes 0x02, 0x03 yield product 0x0006.
- Third UART byte while PENDING -> err_overrun pulses; operands are unchanged. Reset asserted during WAIT_MUL -> every output 0 the next cycle and the FSM in IDLE; a late mul_done produces no TX strobe.
